// File: rtl/decoder_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_arbiter
//
// Purpose
//   Lets NREQ requesters share one decoder. Requests are arbitrated round-robin
//   and only one transaction is in flight at a time. The granted code is held
//   on dec_in for DEC_LAT cycles, dec_out is sampled in the last of those
//   cycles, and the result goes back to the granted requester over a
//   valid/ready handshake.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   CODE_W     decoder input code width
//   DEC_OUT_W  decoder result width
//   DEC_LAT    cycles dec_in is held before dec_out is sampled (1..15)
//
// Ports
//   clock      in   single clock, all state on posedge
//   reset      in   synchronous, active-high
//   req_valid  in   [NREQ]            per-requester request valid
//   req_code   in   [NREQ*CODE_W]     requester i code at [i*CODE_W +: CODE_W]
//   req_ready  out  [NREQ]            one-hot accept, only ever set in IDLE
//   rsp_valid  out  [NREQ]            one-hot result valid (RESP only)
//   rsp_data   out  [DEC_OUT_W]       shared result bus
//   rsp_ready  in   [NREQ]            per-requester result accept
//   dec_in     out  [CODE_W]          code driven to the decoder
//   dec_out    in   [DEC_OUT_W]       decoder result
//   busy       out                    high whenever not IDLE
//
// Optional feature (macro DEC_ARB_STATS_EN)
//   txn_count  out  [16]              completed transactions, saturating
//   last_gnt   out  [$clog2(NREQ)]    requester of the last completed transaction
// ---------------------------------------------------------------------------
module decoder_arbiter #(
    parameter int NREQ      = 4,
    parameter int CODE_W    = 7,
    parameter int DEC_OUT_W = 8,
    parameter int DEC_LAT   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CODE_W-1:0]   req_code,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DEC_OUT_W-1:0]     rsp_data,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [CODE_W-1:0]        dec_in,
    input  logic [DEC_OUT_W-1:0]     dec_out,
    output logic                     busy
`ifdef DEC_ARB_STATS_EN
    ,
    output logic [15:0]              txn_count,
    output logic [$clog2(NREQ)-1:0]  last_gnt
`endif
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q,      gnt_d;
    logic [CODE_W-1:0]   code_q,     code_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [DEC_OUT_W-1:0] rsp_data_q, rsp_data_d;

    logic [CODE_W-1:0]   code_arr [NREQ];
    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic                rsp_done;

    // Split the flat code bus into one lane per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_code_lane
            assign code_arr[gi] = req_code[gi*CODE_W +: CODE_W];
        end
    endgenerate

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign rsp_done = (state_q == ST_RESP) && rsp_ready[gnt_q];

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        code_d     = code_q;
        wait_cnt_d = wait_cnt_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        rsp_valid  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    // Accept completes this cycle; the code is frozen here so
                    // later changes on req_code cannot reach the decoder.
                    req_ready[grant_idx] = 1'b1;
                    code_d     = code_arr[grant_idx];
                    gnt_d      = grant_idx;
                    wait_cnt_d = CNT_W'(DEC_LAT);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == CNT_W'(1)) begin
                    rsp_data_d = dec_out;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_done) begin
                    rr_ptr_d = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            code_q     <= '0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            code_q     <= code_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // code_q only changes at accept, so dec_in is a clean register output
    // that keeps its last value outside WAIT.
    assign dec_in   = code_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef DEC_ARB_STATS_EN
    logic [15:0]       txn_count_q, txn_count_d;
    logic [IDX_W-1:0]  last_gnt_q,  last_gnt_d;

    always_comb begin
        txn_count_d = txn_count_q;
        last_gnt_d  = last_gnt_q;
        if (rsp_done) begin
            if (txn_count_q != 16'hFFFF) begin
                txn_count_d = txn_count_q + 16'd1;
            end
            last_gnt_d = gnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txn_count_q <= '0;
            last_gnt_q  <= '0;
        end else begin
            txn_count_q <= txn_count_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign txn_count = txn_count_q;
    assign last_gnt  = last_gnt_q;
`endif

endmodule

// File: tb/tb_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_decoder_arbiter
//
// Self-checking bench for decoder_arbiter with NREQ=4, DEC_LAT=2 and a
// decoder model dec_out = {1'b0, ~dec_in}. Directed steps plus randomized
// transactions, all compared against a small reference model of the
// round-robin pointer, captured code and statistics.
// ---------------------------------------------------------------------------
module tb_decoder_arbiter;

    localparam int NREQ      = 4;
    localparam int CODE_W    = 7;
    localparam int DEC_OUT_W = 8;
    localparam int DEC_LAT   = 2;

    logic                    clock;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*CODE_W-1:0]  req_code;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         rsp_valid;
    logic [DEC_OUT_W-1:0]    rsp_data;
    logic [NREQ-1:0]         rsp_ready;
    logic [CODE_W-1:0]       dec_in;
    logic [DEC_OUT_W-1:0]    dec_out;
    logic                    busy;
`ifdef DEC_ARB_STATS_EN
    logic [15:0]             txn_count;
    logic [1:0]              last_gnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    int m_ptr   = 0;
    int m_count = 0;
    int m_last  = 0;

    decoder_arbiter #(
        .NREQ(NREQ), .CODE_W(CODE_W), .DEC_OUT_W(DEC_OUT_W), .DEC_LAT(DEC_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .busy      (busy)
`ifdef DEC_ARB_STATS_EN
        ,
        .txn_count (txn_count),
        .last_gnt  (last_gnt)
`endif
    );

    assign dec_out = {1'b0, ~dec_in};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester with valid set, scanning from the
    // pointer and wrapping around.
    function automatic int pick(input int ptr, input logic [NREQ-1:0] vld);
        int rot [$];
        for (int k = 0; k < NREQ; k++) rot.push_back((ptr + k) % NREQ);
        foreach (rot[k]) if (vld[rot[k]]) return rot[k];
        return -1;
    endfunction

    task automatic chk_stats();
`ifdef DEC_ARB_STATS_EN
        chk("txn_count", 32'(txn_count), 32'(m_count));
        chk("last_gnt",  32'(last_gnt),  32'(m_last));
`endif
    endtask

    // One full transaction. Entered just after a negedge with the DUT in
    // IDLE; returns just after the negedge at which it is back in IDLE.
    task automatic run_txn(input logic [NREQ-1:0] vld, input int stall,
                           output int acc_cyc, output int gnt);
        logic [CODE_W-1:0]    code;
        logic [NREQ-1:0]      oh;
        logic [DEC_OUT_W-1:0] exp_data;
        req_code  = NREQ*CODE_W'($urandom);
        req_valid = vld;
        rsp_ready = 4'($urandom);
        gnt       = pick(m_ptr, vld);
        code      = req_code[gnt*CODE_W +: CODE_W];
        oh        = 4'b0001 << gnt;
        exp_data  = {1'b0, ~code};
        #1;
        acc_cyc = cyc;
        chk("idle_req_ready", 32'(req_ready), 32'(oh));
        chk("idle_busy",      32'(busy),      32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        for (int c = 0; c < DEC_LAT; c++) begin
            // Requests and codes churn freely; the transaction must not notice.
            req_valid = 4'($urandom);
            req_code  = NREQ*CODE_W'($urandom);
            #1;
            chk("wait_dec_in",    32'(dec_in),    32'(code));
            chk("wait_busy",      32'(busy),      32'd1);
            chk("wait_req_ready", 32'(req_ready), 32'd0);
            chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clock);
        end
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 4'($urandom) & ~oh;
            req_valid = 4'($urandom);
            #1;
            chk("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("stall_rsp_data",  32'(rsp_data),  32'(exp_data));
            chk("stall_busy",      32'(busy),      32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        rsp_ready = 4'($urandom) | oh;
        #1;
        chk("resp_rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("resp_rsp_data",  32'(rsp_data),  32'(exp_data));
        chk("resp_latency",   32'(cyc - acc_cyc), 32'(DEC_LAT + 1 + stall));
        @(negedge clock);
        m_ptr   = (gnt + 1) % NREQ;
        m_count = (m_count < 65535) ? m_count + 1 : m_count;
        m_last  = gnt;
        #1;
        chk("done_busy",      32'(busy),      32'd0);
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_stats();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_dec_in"},    32'(dec_in),    32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk_stats();
    endtask

    initial begin
        int acc, prev_acc, g;
        logic [CODE_W-1:0] lost_code;

        reset     = 1'b1;
        req_valid = '0;
        req_code  = '0;
        rsp_ready = '0;
        repeat (3) @(negedge clock);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        // Idle with no request: stays idle.
        req_valid = '0;
        #1;
        chk("noreq_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("noreq_busy", 32'(busy), 32'd0);

        // Single requester 0 with a known code.
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        req_code  = {NREQ{7'b1110001}};
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'b0001);
        @(negedge clock);
        req_code = '0;
        #1;
        chk("t1_dec_in_a", 32'(dec_in), 32'b1110001);
        @(negedge clock);
        #1;
        chk("t1_dec_in_b", 32'(dec_in), 32'b1110001);
        @(negedge clock);
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t1_rsp_data",  32'(rsp_data),  32'h0E);
        @(negedge clock);
        m_ptr = 1; m_count = 1; m_last = 0;
        chk_stats();

        // All requesters valid: strict rotation, one accept every 4 cycles.
        run_txn(4'b1111, 0, prev_acc, g);
        for (int n = 0; n < 4; n++) begin
            run_txn(4'b1111, 0, acc, g);
            chk("rr_throughput", 32'(acc - prev_acc), 32'(DEC_LAT + 2));
            prev_acc = acc;
        end

        // Back-pressure held for 5 cycles.
        run_txn(4'b0110, 5, acc, g);

        // Only one requester active: granted every visit.
        for (int n = 0; n < 3; n++) begin
            run_txn(4'b1000, 0, acc, g);
            chk("single_gnt", 32'(g), 32'd3);
        end

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), acc, g);
            repeat ($urandom_range(0, 2)) begin
                req_valid = '0;
                #1;
                chk("gap_req_ready", 32'(req_ready), 32'd0);
                @(negedge clock);
            end
        end

        // Move the pointer off zero, then reset in the middle of WAIT.
        run_txn(4'b0001, 0, acc, g);
        req_valid = 4'b1111;
        req_code  = NREQ*CODE_W'($urandom);
        lost_code = req_code[m_ptr*CODE_W +: CODE_W];
        #1;
        chk("pre_reset_gnt", 32'(req_ready), 32'(4'b0001 << m_ptr));
        @(negedge clock);
        #1;
        chk("pre_reset_dec_in", 32'(dec_in), 32'(lost_code));
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        m_ptr = 0; m_count = 0; m_last = 0;
        #1;
        chk_reset_values("midreset");
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            #1;
            chk("dropped_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("dropped_busy",      32'(busy),      32'd0);
        end
        @(negedge clock);

        // Transactions from requesters 2, 3, 0 after reset.
        run_txn(4'b0100, 0, acc, g);
        chk("stats_gnt_a", 32'(g), 32'd2);
        run_txn(4'b1000, 1, acc, g);
        chk("stats_gnt_b", 32'(g), 32'd3);
        run_txn(4'b0001, 0, acc, g);
        chk("stats_gnt_c", 32'(g), 32'd0);
`ifdef DEC_ARB_STATS_EN
        chk("stats_txn_count", 32'(txn_count), 32'd3);
        chk("stats_last_gnt",  32'(last_gnt),  32'd0);
`endif

        // Full rotation starting from the post-reset pointer.
        run_txn(4'b1111, 0, acc, g);
        chk("post_reset_rr", 32'(g), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
